reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 128 ++++++++++++
 tb/tb_reset_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - PLL-qualified core/boot reset release sequencer with lock-loss retry and sticky fault
module reset_sequencer #(
  parameter int unsigned LOCK_CYCLES = 1000,
  parameter int unsigned CORE_DELAY  = 100000,
  parameter int unsigned BOOT_DELAY  = 100000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       soft_req,
  output logic       core_run,
  output logic       boot_run,
  output logic       seq_done,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] loss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOCK  = 3'd1,
    S_CORE  = 3'd2,
    S_BOOT  = 3'd3,
    S_RUN   = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  // Terminal counter values: a phase ends on the edge where the counter reads N-1.
  localparam logic [31:0] LOCK_LAST  = 32'(LOCK_CYCLES - 1);
  localparam logic [31:0] CORE_LAST  = 32'(CORE_DELAY - 1);
  localparam logic [31:0] BOOT_LAST  = 32'(BOOT_DELAY - 1);
  localparam logic [7:0]  RETRY_LAST = 8'(MAX_RETRY - 1);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [7:0]  loss_d;
  logic        lost;

  assign state = state_q;

  // Next-state, delay counter and lock-loss bookkeeping; soft_req outranks a lock loss.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_cnt;
    lost    = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_LOCK;
        cnt_d   = '0;
      end
      S_LOCK: begin
        if (soft_req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!pll_locked) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_CORE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_CORE, S_BOOT: begin
        if (soft_req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!pll_locked) begin
          lost = 1'b1;
        end else if (cnt_q == ((state_q == S_CORE) ? CORE_LAST : BOOT_LAST)) begin
          state_d = (state_q == S_CORE) ? S_BOOT : S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RUN: begin
        if (soft_req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!pll_locked) begin
          lost = 1'b1;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (lost) begin
      cnt_d   = '0;
      state_d = (loss_cnt == RETRY_LAST) ? S_FAULT : S_LOCK;
      if (loss_cnt != 8'hFF) begin
        loss_d = loss_cnt + 8'd1;
      end
    end
  end

  // State, counter and outputs; outputs are decoded from the next state so they change with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      loss_cnt <= '0;
      core_run <= 1'b0;
      boot_run <= 1'b0;
      seq_done <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      loss_cnt <= loss_d;
      core_run <= (state_d == S_BOOT) || (state_d == S_RUN);
      boot_run <= (state_d == S_RUN);
      seq_done <= (state_d == S_RUN);
      fault    <= (state_d == S_FAULT);
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed and randomized checks of reset_sequencer against a phase-level model
module tb_reset_sequencer;

  localparam int LOCK_CYCLES = 4;
  localparam int CORE_DELAY  = 8;
  localparam int BOOT_DELAY  = 8;
  localparam int MAX_RETRY   = 2;

  logic       clock;
  logic       reset;
  logic       pll_locked;
  logic       soft_req;
  logic       core_run;
  logic       boot_run;
  logic       seq_done;
  logic       fault;
  logic [2:0] state;
  logic [7:0] loss_cnt;

  int errors = 0;
  int checks = 0;

  // Model: current phase, cycles spent qualifying/waiting in it, lock losses seen.
  int m_phase  = 0;
  int m_spent  = 0;
  int m_losses = 0;

  reset_sequencer #(
    .LOCK_CYCLES(LOCK_CYCLES),
    .CORE_DELAY (CORE_DELAY),
    .BOOT_DELAY (BOOT_DELAY),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pll_locked(pll_locked),
    .soft_req  (soft_req),
    .core_run  (core_run),
    .boot_run  (boot_run),
    .seq_done  (seq_done),
    .fault     (fault),
    .state     (state),
    .loss_cnt  (loss_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Phase lengths in cycles: IDLE=0, LOCK=1, CORE=2, BOOT=3, RUN=4, FAULT=5.
  function automatic int phase_len(input int ph);
    case (ph)
      1:       return LOCK_CYCLES;
      2:       return CORE_DELAY;
      3:       return BOOT_DELAY;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit p, input bit s);
    if (r) begin
      m_phase = 0; m_spent = 0; m_losses = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_spent = 0;
    end else if (m_phase == 5) begin
      m_phase = 5;
    end else if (s) begin
      m_phase = 0; m_spent = 0;
    end else if (!p) begin
      if (m_phase == 1) begin
        m_spent = 0;
      end else begin
        m_phase = (m_losses == MAX_RETRY - 1) ? 5 : 1;
        m_spent = 0;
        if (m_losses < 255) m_losses++;
      end
    end else if (m_phase != 4) begin
      m_spent++;
      if (m_spent == phase_len(m_phase)) begin
        m_phase++;
        m_spent = 0;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("state",    32'(state),    32'(m_phase));
    check_eq("core_run", 32'(core_run), 32'(m_phase == 3 || m_phase == 4));
    check_eq("boot_run", 32'(boot_run), 32'(m_phase == 4));
    check_eq("seq_done", 32'(seq_done), 32'(m_phase == 4));
    check_eq("fault",    32'(fault),    32'(m_phase == 5));
    check_eq("loss_cnt", 32'(loss_cnt), 32'(m_losses));
  endtask

  task automatic step(input bit r, input bit p, input bit s);
    reset = r; pll_locked = p; soft_req = s;
    @(posedge clock);
    model_step(r, p, s);
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1; pll_locked = 1'b0; soft_req = 1'b0;

    // Reset state
    step(1, 0, 0);
    step(1, 1, 1);
    check_eq("rst_state", 32'(state), 32'd0);

    // Nominal bring-up with pll held high: edges counted from reset release
    for (int e = 1; e <= 21; e++) begin
      step(0, 1, 0);
      if (e == 1)  check_eq("e1_lock", 32'(state), 32'd1);
      if (e == 4)  check_eq("e4_lock", 32'(state), 32'd1);
      if (e == 5)  check_eq("e5_core", 32'(state), 32'd2);
      if (e == 12) check_eq("e12_core_run", 32'(core_run), 32'd0);
      if (e == 13) check_eq("e13_core_run", 32'(core_run), 32'd1);
      if (e == 20) check_eq("e20_boot_run", 32'(boot_run), 32'd0);
      if (e == 21) check_eq("e21_run", 32'(state), 32'd4);
    end
    for (int i = 0; i < 5; i++) step(0, 1, 0);

    // Lock loss in RUN, relock, second loss to FAULT, soft_req ignored
    step(0, 0, 0);
    check_eq("loss1_state", 32'(state), 32'd1);
    check_eq("loss1_cnt", 32'(loss_cnt), 32'd1);
    for (int i = 0; i < 20; i++) step(0, 1, 0);
    check_eq("relock_run", 32'(state), 32'd4);
    step(0, 0, 0);
    check_eq("loss2_fault", 32'(fault), 32'd1);
    check_eq("loss2_cnt", 32'(loss_cnt), 32'd2);
    step(0, 1, 1);
    step(0, 0, 0);
    check_eq("fault_sticky", 32'(state), 32'd5);

    // Reset out of FAULT, then a one-cycle pll drop while qualifying lock
    step(1, 1, 0);
    check_eq("rst_from_fault", 32'(loss_cnt), 32'd0);
    for (int e = 1; e <= 8; e++) begin
      step(0, (e != 4), 0);
      if (e == 5) check_eq("drop_no_core", 32'(state), 32'd1);
      if (e == 8) check_eq("drop_core_e8", 32'(state), 32'd2);
    end
    check_eq("drop_no_loss", 32'(loss_cnt), 32'd0);

    // Into BOOT, then soft_req and lock loss together
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    check_eq("in_boot", 32'(state), 32'd3);
    step(0, 0, 1);
    check_eq("soft_wins_state", 32'(state), 32'd0);
    check_eq("soft_wins_loss", 32'(loss_cnt), 32'd0);
    for (int i = 0; i < 22; i++) step(0, 1, 0);
    check_eq("replay_run", 32'(state), 32'd4);

    // Lose lock once, then reset mid-CORE
    step(0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0);
    check_eq("mid_core", 32'(state), 32'd2);
    step(1, 1, 0);
    check_eq("rst_mid_core_loss", 32'(loss_cnt), 32'd0);
    check_eq("rst_mid_core_run", 32'(core_run), 32'd0);

    // Randomized stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 59) != 0),
           ($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
